// File: rtl/rv_core_pkg.sv
// Shared core definitions: fetch FSM states and instruction-stream constants.
package rv_core_pkg;

  localparam int unsigned DEFAULT_XLEN = 32;
  localparam int unsigned INSTR_BYTES  = 4;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StHold
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response and decode handoff signals of the fetch stage.
interface fetch_unit_if
  import rv_core_pkg::*;
#(
  parameter int unsigned XLEN = DEFAULT_XLEN
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;

  // Fetch stage side.
  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output if_valid,
    output if_pc,
    output if_instr,
    input  if_ready
  );

  // Memory / decode side.
  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  if_valid,
    input  if_pc,
    input  if_instr,
    output if_ready
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// Fetch program counter register with load enable and reset to the boot address.
module fetch_pc_reg
  import rv_core_pkg::*;
#(
  parameter int unsigned     XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (load_i) begin
      pc_q <= pc_i;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem read, buffered handoff to decode, redirects.
module fetch_unit
  import rv_core_pkg::*;
#(
  parameter int unsigned     XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_unit_if.master    bus,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] fetch_pc
);

  fetch_state_e    state_q;
  logic            drop_q;
  logic            req_valid_q;
  logic            if_valid_q;
  logic [XLEN-1:0] if_pc_q;
  logic [XLEN-1:0] if_instr_q;

  logic            req_hs;
  logic            pc_load;
  logic [XLEN-1:0] pc_next;

  fetch_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (pc_load),
    .pc_i   (pc_next),
    .pc_o   (fetch_pc)
  );

  // Redirect wins; otherwise the PC only moves when decode takes the held instruction.
  always_comb begin
    req_hs  = req_valid_q & bus.imem_req_ready;
    pc_load = redirect_valid | ((state_q == StHold) & bus.if_ready);
    pc_next = fetch_pc + XLEN'(INSTR_BYTES);
    if (redirect_valid) begin
      pc_next = redirect_pc & ~XLEN'(3);
    end
  end

  // req_valid is registered so the first request appears on the first edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StReq;
      drop_q      <= 1'b0;
      req_valid_q <= 1'b0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= '0;
      if_instr_q  <= XLEN'(NOP_INSTR);
    end else begin
      unique case (state_q)
        StReq: begin
          if (req_hs) begin
            state_q     <= StWait;
            req_valid_q <= 1'b0;
            drop_q      <= redirect_valid;
          end else begin
            req_valid_q <= 1'b1;
          end
        end
        StWait: begin
          if (redirect_valid) begin
            if (bus.imem_rsp_valid) begin
              state_q     <= StReq;
              req_valid_q <= 1'b1;
              drop_q      <= 1'b0;
            end else begin
              drop_q <= 1'b1;
            end
          end else if (bus.imem_rsp_valid) begin
            if (drop_q) begin
              state_q     <= StReq;
              req_valid_q <= 1'b1;
              drop_q      <= 1'b0;
            end else begin
              state_q    <= StHold;
              if_valid_q <= 1'b1;
              if_pc_q    <= fetch_pc;
              if_instr_q <= bus.imem_rsp_data;
            end
          end
        end
        StHold: begin
          if (redirect_valid || bus.if_ready) begin
            state_q     <= StReq;
            req_valid_q <= 1'b1;
            if_valid_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= StReq;
          req_valid_q <= 1'b1;
          if_valid_q  <= 1'b0;
          drop_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.if_valid       = if_valid_q;
  assign bus.if_pc          = if_pc_q;
  assign bus.if_instr       = if_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_pc;

  int n_checks;
  int n_errors;

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_pc       (fetch_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_if(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] instr);
    check({tag, ".if_valid"}, 32'(bus.if_valid), 32'(v));
    check({tag, ".if_pc"},    bus.if_pc,         pc);
    check({tag, ".if_instr"}, bus.if_instr,      instr);
  endtask

  task automatic check_req(input string tag, input logic v, input logic [31:0] addr);
    check({tag, ".req_valid"}, 32'(bus.imem_req_valid), 32'(v));
    if (v) check({tag, ".req_addr"}, bus.imem_req_addr, addr);
  endtask

  initial begin
    n_checks           = 0;
    n_errors           = 0;
    rst_n              = 1'b1;
    redirect_valid     = 1'b0;
    redirect_pc        = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.if_ready       = 1'b0;
    #1 rst_n = 1'b0;
    step();
    step();

    // Reset state
    check_req("rst", 1'b0, 32'h0);
    check_if("rst", 1'b0, 32'h0, 32'h0000_0013);
    check("rst.fetch_pc", fetch_pc, 32'h0);

    // Basic fetch and best-case latency
    bus.imem_req_ready = 1'b1;
    bus.if_ready       = 1'b1;
    rst_n              = 1'b1;
    check_req("rel", 1'b0, 32'h0);
    step();
    check_req("first_req", 1'b1, 32'h0);
    step();
    check_req("wait0", 1'b0, 32'h0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0050_0093;
    step();
    bus.imem_rsp_valid = 1'b0;
    check_if("hold0", 1'b1, 32'h0, 32'h0050_0093);
    check_req("hold0", 1'b0, 32'h0);
    step();
    check_req("next_req", 1'b1, 32'h4);
    check("next.if_valid", 32'(bus.if_valid), 32'd0);

    // Decode stalls for 5 cycles in HOLD
    bus.if_ready = 1'b0;
    step();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h00a0_0113;
    step();
    bus.imem_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_if("stall", 1'b1, 32'h4, 32'h00a0_0113);
      check_req("stall", 1'b0, 32'h0);
      check("stall.fetch_pc", fetch_pc, 32'h4);
      step();
    end
    bus.if_ready = 1'b1;
    step();
    check_req("after_stall", 1'b1, 32'h8);
    check("after_stall.if_valid", 32'(bus.if_valid), 32'd0);

    // Memory not ready for 3 cycles
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_req("busy", 1'b1, 32'h8);
    end
    bus.imem_req_ready = 1'b1;
    step();
    check_req("busy_acc", 1'b0, 32'h0);
    step();
    step();
    check_req("busy_wait", 1'b0, 32'h0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0000_0297;
    step();
    bus.imem_rsp_valid = 1'b0;
    check_if("busy_rsp", 1'b1, 32'h8, 32'h0000_0297);
    step();
    check_req("busy_next", 1'b1, 32'hC);

    // Redirect while waiting, response dropped
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    check("redir_wait.fetch_pc", fetch_pc, 32'h0000_0100);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    bus.imem_rsp_valid = 1'b0;
    check("redir_wait.if_valid", 32'(bus.if_valid), 32'd0);
    check_req("redir_wait", 1'b1, 32'h0000_0100);

    // Redirect together with if_ready in HOLD
    step();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h1111_1111;
    step();
    bus.imem_rsp_valid = 1'b0;
    check_if("redir_hold0", 1'b1, 32'h100, 32'h1111_1111);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    check("redir_hold.if_valid", 32'(bus.if_valid), 32'd0);
    check_req("redir_hold", 1'b1, 32'h0000_0200);

    // Redirect together with the request handshake
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    step();
    redirect_valid = 1'b0;
    check_req("redir_req", 1'b0, 32'h0);
    check("redir_req.fetch_pc", fetch_pc, 32'h0000_0300);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h2222_2222;
    step();
    bus.imem_rsp_valid = 1'b0;
    check("redir_req.if_valid", 32'(bus.if_valid), 32'd0);
    check_req("redir_req_next", 1'b1, 32'h0000_0300);

    // PC wraps from FFFF_FFFC to 0
    bus.imem_req_ready = 1'b0;
    redirect_valid     = 1'b1;
    redirect_pc        = 32'hFFFF_FFFC;
    step();
    redirect_valid     = 1'b0;
    check_req("wrap_req", 1'b1, 32'hFFFF_FFFC);
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h3333_3333;
    step();
    bus.imem_rsp_valid = 1'b0;
    check_if("wrap_hold", 1'b1, 32'hFFFF_FFFC, 32'h3333_3333);
    step();
    check_req("wrap_next", 1'b1, 32'h0);

    // Reset asserted in WAIT, late response ignored afterwards
    step();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h4444_4444;
    step();
    bus.imem_rsp_valid = 1'b0;
    step();
    check_req("pre_rst", 1'b1, 32'h4);
    step();
    check_req("pre_rst_wait", 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    check_req("mid_rst", 1'b0, 32'h0);
    check_if("mid_rst", 1'b0, 32'h0, 32'h0000_0013);
    check("mid_rst.fetch_pc", fetch_pc, 32'h0);
    step();
    rst_n              = 1'b1;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h5555_5555;
    step();
    bus.imem_rsp_valid = 1'b0;
    check("late_rsp.if_valid", 32'(bus.if_valid), 32'd0);
    check_req("restart", 1'b1, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
